// File: rtl/aes_pkg.sv
// Shared AES arbitration constants and the request-arbiter FSM encoding.
package aes_pkg;

    localparam int AES_BLK_W          = 128;
    localparam int AES_KEY_W          = 128;
    localparam int AES_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } aes_state_e;

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Requester-side bundle: operand channel in, ciphertext response channel out.
interface aes_req_arbiter_if #(
    parameter int N_REQ = 2
);
    import aes_pkg::*;

    // valid/ready on both channels: a transfer happens on a rising clk edge
    // where valid and ready are both high. The arbiter raises req_ready only
    // for the granted requester, and rsp_valid only for the job owner.
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*AES_BLK_W-1:0] req_plain;
    logic [N_REQ*AES_KEY_W-1:0] req_key;
    logic [N_REQ-1:0]           rsp_valid;
    logic [N_REQ-1:0]           rsp_ready;
    logic [AES_BLK_W-1:0]       rsp_cipher;
    logic                       rsp_error;

    modport slave (
        input  req_valid, req_plain, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_cipher, rsp_error
    );

    modport master (
        output req_valid, req_plain, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_cipher, rsp_error
    );

endinterface

// File: rtl/aes_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_req
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        // ptr itself is searched last, so the previous owner has lowest priority
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between N_REQ requesters: round-robin grant, start pulse,
// done/timeout wait, and a per-owner ciphertext response.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_req_arbiter_if.slave      req_if,
    output logic                  core_enable,
    output logic [AES_BLK_W-1:0]  core_plain,
    output logic [AES_KEY_W-1:0]  core_key,
    input  logic                  core_done,
    input  logic [AES_BLK_W-1:0]  core_cipher,
    output logic                  busy,
    output aes_state_e            state_dbg
);

    localparam int PTR_W = $clog2(N_REQ);

    aes_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [AES_BLK_W-1:0] plain_q;
    logic [AES_KEY_W-1:0] key_q;
    logic [AES_BLK_W-1:0] cipher_q;
    logic                 err_q;

    logic [N_REQ-1:0]     grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 any_req;
    logic                 timeout_hit;
    logic                 owner_ack;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req_if.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign owner_ack   = req_if.rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (any_req) state_d = START;
            START: state_d = WAIT;
            WAIT:  if (core_done || timeout_hit) state_d = RESP;
            RESP:  if (owner_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_if.req_ready = '0;
        req_if.rsp_valid = '0;
        core_enable      = 1'b0;
        busy             = (state_q != IDLE);
        unique case (state_q)
            IDLE:  req_if.req_ready = grant;
            START: core_enable = 1'b1;
            WAIT:  ;
            RESP:  req_if.rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers; done takes priority over a same-cycle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= PTR_W'(N_REQ - 1);
            owner_q  <= '0;
            cnt_q    <= '0;
            plain_q  <= '0;
            key_q    <= '0;
            cipher_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        plain_q <= req_if.req_plain[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
                        key_q   <= req_if.req_key[int'(grant_idx)*AES_KEY_W +: AES_KEY_W];
                        owner_q <= grant_idx;
                    end
                end
                START: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (core_done) begin
                        cipher_q <= core_cipher;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        cipher_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                RESP: if (owner_ack) ptr_q <= owner_q;
                default: ;
            endcase
        end
    end

    assign core_plain        = plain_q;
    assign core_key          = key_q;
    assign req_if.rsp_cipher = cipher_q;
    assign req_if.rsp_error  = err_q;
    assign state_dbg         = state_q;

endmodule
